// File: rtl/flb_pkg.sv
// ---------------------------------------------------------------------------
// flb_pkg
//   Shared constants and types for the FLB digital loop filter.
//   - Fixed datapath widths (error, output word, integrator, internal sums)
//   - Offset-binary mid-scale value
//   - Loop-filter state enumeration
// ---------------------------------------------------------------------------
package flb_pkg;

  // Signed frequency-error width.
  localparam int ERR_W  = 12;
  // Output word width (offset binary).
  localparam int DLF_W  = 16;
  // Integrator fractional bits.
  localparam int FRAC_W = 8;
  // Integrator width: integer part matches the output word.
  localparam int ACC_W  = DLF_W + FRAC_W;

  // Largest shift values encodable by the gain CSRs.
  localparam int KP_MAX = 7;
  localparam int KI_MAX = 15;

  // Integrator add width: the largest shifted error (ERR_W + KI_MAX bits)
  // plus a full-scale accumulator must never wrap before clamping.
  localparam int INC_W  = ACC_W + 4;
  // Proportional term width at maximum kp.
  localparam int PROP_W = ERR_W + KP_MAX;
  // Integer part of acc plus proportional term, one guard bit.
  localparam int SUM_W  = PROP_W + 1;

  // Lock counter width (LOCK_THR is limited to 1..255).
  localparam int LOCK_CNT_W = 8;

  // Offset-binary zero correction.
  localparam logic [DLF_W-1:0] DLF_MID = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } dlf_state_t;

endpackage

// File: rtl/flb_sat_clamp.sv
// ---------------------------------------------------------------------------
// flb_sat_clamp
//   Generic signed saturating narrowing clamp. Values outside the signed
//   OUT_W range are replaced by the nearest limit and 'sat' is raised.
//   Purely combinational.
// Ports
//   din   in   IN_W   signed input (IN_W > OUT_W)
//   dout  out  OUT_W  clamped signed result
//   sat   out  1      1 when din was outside the OUT_W range
// ---------------------------------------------------------------------------
module flb_sat_clamp #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // Output-range limits expressed at input width so the compare is exact.
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/flb_dlf.sv
// ---------------------------------------------------------------------------
// flb_dlf
//   Digital loop filter for the FLB loop (ref_clk domain, feeds SYNC).
//   Forms a PI correction from a signed per-sample frequency error:
//   proportional term err*2^kp plus a saturating integrator that gains
//   err*2^ki/2^FRAC_W per sample. Output is offset binary (0x8000 = zero).
//   Two-stage pipe: a sample accepted at cycle N shows dlf_vld at N+2.
// Ports
//   ref_clk         in   1        loop clock
//   rst             in   1        async active-high reset
//   err_in          in   ERR_W    signed frequency error
//   err_vld         in   1        error sample valid
//   csr_dlf_en      in   1        filter enable (0 forces IDLE, flushes pipe)
//   csr_dlf_freeze  in   1        hold state, ignore new samples
//   csr_kp_shift    in   3        proportional shift
//   csr_ki_shift    in   4        integral shift
//   csr_dlf_init    in   DLF_W    preset for output/integrator in INIT
//   csr_lock_win    in   ERR_W-1  |err| <= win counts as in-window
//   dlf_out         out  DLF_W    filter output word
//   dlf_vld         out  1        strobe: dlf_out updated
//   dlf_sat         out  1        this sample hit a clamp (with dlf_vld)
//   dlf_lock        out  1        loop locked
// ---------------------------------------------------------------------------
module flb_dlf
  import flb_pkg::*;
#(
  parameter int LOCK_THR = 16
) (
  input  logic                    ref_clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    err_vld,
  input  logic                    csr_dlf_en,
  input  logic                    csr_dlf_freeze,
  input  logic [2:0]              csr_kp_shift,
  input  logic [3:0]              csr_ki_shift,
  input  logic [DLF_W-1:0]        csr_dlf_init,
  input  logic [ERR_W-2:0]        csr_lock_win,
  output logic [DLF_W-1:0]        dlf_out,
  output logic                    dlf_vld,
  output logic                    dlf_sat,
  output logic                    dlf_lock
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = LOCK_CNT_W'(LOCK_THR);

  dlf_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic [LOCK_CNT_W-1:0]    lock_cnt;

  // Stage-1 registers: everything S2 needs about the in-flight sample.
  logic                     s1_vld;
  logic signed [PROP_W-1:0] s1_prop;
  logic                     s1_isat;
  logic                     s1_inwin;

  // ---------------------------------------------------------------------
  // S1 combinational: integrator update, proportional term, lock window
  // ---------------------------------------------------------------------
  logic                     accept;
  logic signed [INC_W-1:0]  err_ext;
  logic signed [INC_W-1:0]  inc;
  logic signed [INC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_clamped;
  logic                     int_sat;
  logic signed [PROP_W-1:0] prop_ext;
  logic signed [PROP_W-1:0] prop_next;
  logic [ERR_W:0]           err_wide;
  logic [ERR_W:0]           abs_err;
  logic                     in_win;
  logic signed [ACC_W-1:0]  init_acc;

  // Freeze in the same cycle drops the sample even while still in TRACK.
  assign accept = (state == TRACK) && err_vld && !csr_dlf_freeze;

  assign err_ext  = {{(INC_W-ERR_W){err_in[ERR_W-1]}}, err_in};
  assign inc      = err_ext <<< csr_ki_shift;
  assign acc_sum  = {{(INC_W-ACC_W){acc[ACC_W-1]}}, acc} + inc;

  assign prop_ext  = {{(PROP_W-ERR_W){err_in[ERR_W-1]}}, err_in};
  assign prop_next = prop_ext <<< csr_kp_shift;

  // One extra bit so the most negative error has a representable magnitude;
  // it can never fall inside an ERR_W-1 bit window.
  assign err_wide = {err_in[ERR_W-1], err_in};
  assign abs_err  = err_in[ERR_W-1] ? (~err_wide + 1'b1) : err_wide;
  assign in_win   = abs_err <= {2'b00, csr_lock_win};

  // (init - mid) as a signed integer, scaled into integrator units.
  assign init_acc = {~csr_dlf_init[DLF_W-1], csr_dlf_init[DLF_W-2:0], {FRAC_W{1'b0}}};

  // The integrator is stored clamped, so a saturated loop recovers as soon
  // as the error changes sign instead of first unwinding hidden excess.
  flb_sat_clamp #(
    .IN_W  (INC_W),
    .OUT_W (ACC_W)
  ) u_int_clamp (
    .din  (acc_sum),
    .dout (acc_clamped),
    .sat  (int_sat)
  );

  // ---------------------------------------------------------------------
  // S2 combinational: integer part of the (already updated) acc plus prop
  // ---------------------------------------------------------------------
  logic signed [SUM_W-1:0] out_sum;
  logic signed [DLF_W-1:0] out_clamped;
  logic                    out_sat;
  logic [LOCK_CNT_W-1:0]   cnt_inc;

  assign out_sum = {{(SUM_W-DLF_W){acc[ACC_W-1]}}, acc[ACC_W-1:FRAC_W]}
                 + {{(SUM_W-PROP_W){s1_prop[PROP_W-1]}}, s1_prop};

  flb_sat_clamp #(
    .IN_W  (SUM_W),
    .OUT_W (DLF_W)
  ) u_out_clamp (
    .din  (out_sum),
    .dout (out_clamped),
    .sat  (out_sat)
  );

  assign cnt_inc = (lock_cnt >= LOCK_CNT_MAX) ? LOCK_CNT_MAX : lock_cnt + 1'b1;

  // ---------------------------------------------------------------------
  // FSM, pipeline and lock counter
  // ---------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values; S2 therefore reads acc as left by the previous
  // sample's S1 even when a new sample updates it on the same edge.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      lock_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_prop  <= '0;
      s1_isat  <= 1'b0;
      s1_inwin <= 1'b0;
      dlf_out  <= DLF_MID;
      dlf_vld  <= 1'b0;
      dlf_sat  <= 1'b0;
      dlf_lock <= 1'b0;
    end else if (!csr_dlf_en) begin
      // Disable flushes the pipe and lock; acc and dlf_out keep their values
      // because INIT presets them before they are used again.
      state    <= IDLE;
      s1_vld   <= 1'b0;
      dlf_vld  <= 1'b0;
      dlf_sat  <= 1'b0;
      dlf_lock <= 1'b0;
      lock_cnt <= '0;
    end else begin
      // S1: latch everything about an accepted sample, including the gains
      // in effect now, so later CSR writes do not touch it.
      s1_vld <= accept;
      if (accept) begin
        acc      <= acc_clamped;
        s1_prop  <= prop_next;
        s1_isat  <= int_sat;
        s1_inwin <= in_win;
      end

      // S2: completes regardless of HOLD.
      dlf_vld <= s1_vld;
      dlf_sat <= s1_vld && (s1_isat || out_sat);
      if (s1_vld) begin
        dlf_out <= DLF_MID ^ out_clamped;
        if (s1_inwin) begin
          lock_cnt <= cnt_inc;
          dlf_lock <= (cnt_inc == LOCK_CNT_MAX);
        end else begin
          lock_cnt <= '0;
          dlf_lock <= 1'b0;
        end
      end

      unique case (state)
        IDLE: begin
          state    <= INIT;
          lock_cnt <= '0;
          dlf_lock <= 1'b0;
        end
        INIT: begin
          acc     <= init_acc;
          dlf_out <= csr_dlf_init;
          state   <= TRACK;
        end
        TRACK: begin
          if (csr_dlf_freeze) state <= HOLD;
        end
        HOLD: begin
          if (!csr_dlf_freeze) state <= TRACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flb_dlf.sv
// ---------------------------------------------------------------------------
// tb_flb_dlf
//   Self-checking bench for flb_dlf. A behavioural model using plain
//   integer arithmetic predicts dlf_out/vld/sat/lock every cycle; directed
//   sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_flb_dlf;

  localparam int LOCK_THR = 16;

  logic               ref_clk;
  logic               rst;
  logic signed [11:0] err_in;
  logic               err_vld;
  logic               csr_dlf_en;
  logic               csr_dlf_freeze;
  logic [2:0]         csr_kp_shift;
  logic [3:0]         csr_ki_shift;
  logic [15:0]        csr_dlf_init;
  logic [10:0]        csr_lock_win;
  logic [15:0]        dlf_out;
  logic               dlf_vld;
  logic               dlf_sat;
  logic               dlf_lock;

  flb_dlf #(.LOCK_THR(LOCK_THR)) dut (
    .ref_clk        (ref_clk),
    .rst            (rst),
    .err_in         (err_in),
    .err_vld        (err_vld),
    .csr_dlf_en     (csr_dlf_en),
    .csr_dlf_freeze (csr_dlf_freeze),
    .csr_kp_shift   (csr_kp_shift),
    .csr_ki_shift   (csr_ki_shift),
    .csr_dlf_init   (csr_dlf_init),
    .csr_lock_win   (csr_lock_win),
    .dlf_out        (dlf_out),
    .dlf_vld        (dlf_vld),
    .dlf_sat        (dlf_sat),
    .dlf_lock       (dlf_lock)
  );

  bit clk_run = 1'b0;
  initial ref_clk = 1'b0;
  always begin
    #5;
    if (clk_run) ref_clk = ~ref_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // -------------------------------------------------------------------
  // Behavioural model: integers, one pending result per accepted sample.
  // -------------------------------------------------------------------
  int          m_mode;      // 0 idle, 1 init, 2 track, 3 hold
  longint      m_acc;
  int          m_cnt;
  bit          p_vld, p_sat, p_lock;
  int          p_out;
  logic [15:0] m_out;
  bit          m_vld, m_sat, m_lock;

  task automatic model_sample();
    longint e, a, s, prop;
    int     mag;
    bit     si, so;
    e  = longint'(err_in);
    a  = m_acc + e * (longint'(1) << csr_ki_shift);
    si = 1'b0;
    if (a > 64'sd8388607)   begin a = 64'sd8388607;  si = 1'b1; end
    if (a < -64'sd8388608)  begin a = -64'sd8388608; si = 1'b1; end
    m_acc = a;
    prop  = e * (longint'(1) << csr_kp_shift);
    s     = (m_acc >>> 8) + prop;
    so    = 1'b0;
    if (s > 32767)  begin s = 32767;  so = 1'b1; end
    if (s < -32768) begin s = -32768; so = 1'b1; end
    p_out = int'(s) + 32768;
    p_sat = si || so;
    mag   = (e < 0) ? int'(-e) : int'(e);
    if (mag <= int'(csr_lock_win)) begin
      if (m_cnt < LOCK_THR) m_cnt++;
      p_lock = (m_cnt == LOCK_THR);
    end else begin
      m_cnt  = 0;
      p_lock = 1'b0;
    end
    p_vld = 1'b1;
  endtask

  always @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_acc = 0; m_cnt = 0; p_vld = 1'b0;
      m_out = 16'h8000; m_vld = 1'b0; m_sat = 1'b0; m_lock = 1'b0;
    end else if (!csr_dlf_en) begin
      m_mode = 0; m_cnt = 0; p_vld = 1'b0;
      m_vld = 1'b0; m_sat = 1'b0; m_lock = 1'b0;
    end else begin
      m_vld = p_vld;
      m_sat = p_vld && p_sat;
      if (p_vld) begin
        m_out  = p_out[15:0];
        m_lock = p_lock;
      end
      p_vld = 1'b0;
      case (m_mode)
        0: begin m_mode = 1; m_cnt = 0; m_lock = 1'b0; end
        1: begin
          m_acc  = (longint'(csr_dlf_init) - 32768) * 256;
          m_out  = csr_dlf_init;
          m_mode = 2;
        end
        2: if (csr_dlf_freeze) m_mode = 3; else if (err_vld) model_sample();
        default: if (!csr_dlf_freeze) m_mode = 2;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ref_clk) begin
    if (cmp_on) begin
      check("cyc_vld",  32'(dlf_vld),  32'(m_vld));
      check("cyc_out",  32'(dlf_out),  32'(m_out));
      check("cyc_sat",  32'(dlf_sat),  32'(m_sat));
      check("cyc_lock", 32'(dlf_lock), 32'(m_lock));
    end
  end

  // -------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------
  task automatic tick();
    @(negedge ref_clk);
  endtask

  task automatic enable_filter(input logic [15:0] init);
    csr_dlf_init = init;
    csr_dlf_en   = 1'b1;
    tick();  // IDLE -> INIT
    tick();  // INIT applied, now TRACK
  endtask

  task automatic restart(input logic [15:0] init);
    err_vld    = 1'b0;
    csr_dlf_en = 1'b0;
    tick();
    enable_filter(init);
  endtask

  task automatic wait_vld(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      tick();
      seen = dlf_vld;
    end
  endtask

  bit seen;

  initial begin
    rst = 1'b0; err_in = '0; err_vld = 1'b0; csr_dlf_en = 1'b0;
    csr_dlf_freeze = 1'b0; csr_kp_shift = '0; csr_ki_shift = '0;
    csr_dlf_init = 16'h8000; csr_lock_win = '0;

    // 1: async reset with the clock stopped, then INIT preset.
    #2 rst = 1'b1;
    #1;
    check("rst_out",  32'(dlf_out),  32'h8000);
    check("rst_vld",  32'(dlf_vld),  32'h0);
    check("rst_sat",  32'(dlf_sat),  32'h0);
    check("rst_lock", 32'(dlf_lock), 32'h0);
    cmp_on  = 1'b1;
    clk_run = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    enable_filter(16'h9000);
    check("init_out", 32'(dlf_out), 32'h9000);

    // 2: kp=0 ki=8 err=+1 -> k-th output is 0x8000 + k + 1.
    restart(16'h8000);
    csr_kp_shift = 3'd0; csr_ki_shift = 4'd8; err_in = 12'sd1;
    for (int i = 0; i < 8; i++) begin
      err_vld = (i < 6);
      tick();
      if (i >= 1 && i <= 6) begin
        check("ramp_vld", 32'(dlf_vld), 32'h1);
        check("ramp_out", 32'(dlf_out), 32'h8000 + 32'(i) + 32'h1);
      end
      if (i == 7) check("ramp_end_vld", 32'(dlf_vld), 32'h0);
    end

    // 3: saturation and anti-windup. First sample clamps both acc
    // (0x7FF000 + 2047*2^15 -> 0x7FFFFF) and output (32767+262016 -> 32767).
    // Second sample: acc 0x7FFFFF-256 = 0x7FFEFF -> 32766, prop -1 -> 32765.
    restart(16'hFFF0);
    csr_kp_shift = 3'd7; csr_ki_shift = 4'd15; err_in = 12'sd2047; err_vld = 1'b1;
    tick();
    csr_kp_shift = 3'd0; csr_ki_shift = 4'd8; err_in = -12'sd1;
    tick();
    err_vld = 1'b0;
    check("sat_out", 32'(dlf_out), 32'hFFFF);
    check("sat_flag", 32'(dlf_sat), 32'h1);
    tick();
    check("unwind_out", 32'(dlf_out), 32'hFFFD);
    check("unwind_sat", 32'(dlf_sat), 32'h0);

    // 4: lock after 16 in-window samples, lost on one out-of-window sample.
    restart(16'h8000);
    csr_kp_shift = 3'd0; csr_ki_shift = 4'd0; csr_lock_win = 11'd4;
    for (int i = 0; i < 18; i++) begin
      err_vld = (i < 17);
      err_in  = (i == 16) ? 12'sd5 : ((i % 2) != 0 ? -12'sd3 : 12'sd3);
      tick();
      if (i >= 1) check("lock_seq", 32'(dlf_lock), (i == 16) ? 32'h1 : 32'h0);
    end

    // 5: freeze holds acc and output; release resumes from held acc.
    restart(16'h8000);
    csr_kp_shift = 3'd1; csr_ki_shift = 4'd8; err_in = 12'sd10;
    for (int i = 0; i < 3; i++) begin
      err_vld = 1'b1;
      tick();
    end
    csr_dlf_freeze = 1'b1;
    tick();
    check("frz_last_vld", 32'(dlf_vld), 32'h1);
    check("frz_last_out", 32'(dlf_out), 32'h8032);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("frz_hold_vld", 32'(dlf_vld), 32'h0);
      check("frz_hold_out", 32'(dlf_out), 32'h8032);
    end
    csr_dlf_freeze = 1'b0;
    wait_vld(6, seen);
    check("frz_resume_seen", 32'(seen), 32'h1);
    check("frz_resume_out", 32'(dlf_out), 32'h803C);
    err_vld = 1'b0;
    tick();

    // 6a: lock up, then disable with a sample in flight.
    restart(16'h8400);
    csr_kp_shift = 3'd0; csr_ki_shift = 4'd0; err_in = 12'sd0;
    err_vld = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("dis_pre_lock", 32'(dlf_lock), 32'h1);
    check("dis_pre_out", 32'(dlf_out), 32'h8400);
    tick();
    err_vld    = 1'b0;
    csr_dlf_en = 1'b0;
    tick();
    check("dis_vld", 32'(dlf_vld), 32'h0);
    check("dis_lock", 32'(dlf_lock), 32'h0);
    check("dis_out_held", 32'(dlf_out), 32'h8400);
    tick();
    check("dis_vld2", 32'(dlf_vld), 32'h0);

    // 6b: async reset in the middle of TRACK.
    enable_filter(16'h8000);
    csr_kp_shift = 3'd2; csr_ki_shift = 4'd4; err_in = 12'sd100; err_vld = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    @(posedge ref_clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out",  32'(dlf_out),  32'h8000);
    check("mid_rst_vld",  32'(dlf_vld),  32'h0);
    check("mid_rst_lock", 32'(dlf_lock), 32'h0);
    check("mid_rst_sat",  32'(dlf_sat),  32'h0);
    err_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
